// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
//   Decides when the next obstacle appears and what it is, and keeps up to
//   NSLOT live obstacles scrolling left. Spawn timing and motion only advance
//   on frame_tick while run is high.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   run            1 = game running, 0 = paused (everything frozen)
//   clear          synchronous restart: drop all obstacles, reload the gap
//   frame_tick     one-cycle pulse per video frame
//   speed          pixels moved per frame_tick
//   rnd            free-running random word, sampled only in SPAWN
//   obs_valid      per-slot live flag
//   obs_x          per-slot x at [i*XW +: XW]
//   obs_type       per-slot type at [i*2 +: 2] (0 small, 1 large, 2 group, 3 bird)
//   spawn_pulse    one cycle: an obstacle was placed
//   dropped        one cycle: a spawn was due but every slot was busy
// -----------------------------------------------------------------------------
module obstacle_spawner #(
  parameter int NSLOT    = 4,
  parameter int XW       = 10,
  parameter int SCREEN_X = 640,
  parameter int MIN_GAP  = 40,
  parameter int GAPB     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic                  frame_tick,
  input  logic [3:0]            speed,
  input  logic [29:0]           rnd,
  output logic [NSLOT-1:0]      obs_valid,
  output logic [NSLOT*XW-1:0]   obs_x,
  output logic [NSLOT*2-1:0]    obs_type,
  output logic                  spawn_pulse,
  output logic                  dropped
);

  // Gap counter must hold MIN_GAP plus the largest random increment.
  localparam int GW = $clog2(MIN_GAP + (1 << GAPB));
  localparam logic [XW-1:0] SPAWN_X   = XW'(SCREEN_X - 1);
  localparam logic [GW-1:0] GAP_RESET = GW'(MIN_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SPAWN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [NSLOT-1:0]      obs_valid_q, obs_valid_d;
  logic [NSLOT*XW-1:0]   obs_x_q, obs_x_d;
  logic [NSLOT*2-1:0]    obs_type_q, obs_type_d;
  logic                  spawn_pulse_q, spawn_pulse_d;
  logic                  dropped_q, dropped_d;

  logic                  move_s;
  logic                  slot_taken_s;
  logic [XW-1:0]         speed_ext_s;
  logic                  rnd_unused;

  assign speed_ext_s = {{(XW-4){1'b0}}, speed};
  // Only the type and gap fields of the random word are consumed.
  assign rnd_unused  = ^rnd[29:GAPB+2];

  // Next-state, gap counter, slot motion and spawn placement.
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    obs_valid_d   = obs_valid_q;
    obs_x_d       = obs_x_q;
    obs_type_d    = obs_type_q;
    spawn_pulse_d = 1'b0;
    dropped_d     = 1'b0;
    slot_taken_s  = 1'b0;
    move_s        = frame_tick & run;

    // Motion applies in every state; a slot that cannot move a full step exits.
    for (int i = 0; i < NSLOT; i++) begin
      if (move_s && obs_valid_q[i]) begin
        if (obs_x_q[i*XW +: XW] < speed_ext_s) begin
          obs_valid_d[i] = 1'b0;
        end else begin
          obs_x_d[i*XW +: XW] = obs_x_q[i*XW +: XW] - speed_ext_s;
        end
      end else begin
        obs_x_d[i*XW +: XW] = obs_x_q[i*XW +: XW];
      end
    end

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!run) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (gap_cnt_q == GW'(1'b1)) begin
            state_d   = SPAWN;
            gap_cnt_d = '0;
          end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GW'(1'b1);
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end else begin
          state_d = WAIT;
        end
      end
      SPAWN: begin
        // Free-slot search uses the registered valids, so a slot freed by
        // motion in this same cycle is not reused until the next spawn.
        for (int i = 0; i < NSLOT; i++) begin
          if (!slot_taken_s && !obs_valid_q[i]) begin
            slot_taken_s          = 1'b1;
            obs_valid_d[i]        = 1'b1;
            obs_x_d[i*XW +: XW]   = SPAWN_X;
            obs_type_d[i*2 +: 2]  = rnd[1:0];
          end else begin
            slot_taken_s = slot_taken_s;
          end
        end
        spawn_pulse_d = slot_taken_s;
        dropped_d     = ~slot_taken_s;
        gap_cnt_d     = GAP_RESET + GW'(rnd[GAPB+1:2]);
        if (run) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Restart overrides motion, counting and any spawn in progress.
    if (clear) begin
      obs_valid_d   = '0;
      obs_x_d       = obs_x_q;
      obs_type_d    = obs_type_q;
      gap_cnt_d     = GAP_RESET;
      spawn_pulse_d = 1'b0;
      dropped_d     = 1'b0;
      if (run) begin
        state_d = WAIT;
      end else begin
        state_d = IDLE;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gap_cnt_q     <= GAP_RESET;
      obs_valid_q   <= '0;
      obs_x_q       <= '0;
      obs_type_q    <= '0;
      spawn_pulse_q <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      obs_valid_q   <= obs_valid_d;
      obs_x_q       <= obs_x_d;
      obs_type_q    <= obs_type_d;
      spawn_pulse_q <= spawn_pulse_d;
      dropped_q     <= dropped_d;
    end
  end

  assign obs_valid   = obs_valid_q;
  assign obs_x       = obs_x_q;
  assign obs_type    = obs_type_q;
  assign spawn_pulse = spawn_pulse_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// -----------------------------------------------------------------------------
// tb_obstacle_spawner
//   Frame-level reference model of the spawner. Each frame the model predicts
//   motion and, when the gap expires, pushes the expected spawn/drop event to
//   a scoreboard queue; a negedge monitor pops and checks every event the DUT
//   emits. Slot state is compared against the model after every frame.
// -----------------------------------------------------------------------------
module tb_obstacle_spawner;

  localparam int NSLOT = 4;
  localparam int XW    = 10;
  localparam int SX    = 639;
  localparam int MGAP  = 40;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                run;
  logic                clear;
  logic                frame_tick;
  logic [3:0]          speed;
  logic [29:0]         rnd;
  logic [NSLOT-1:0]    obs_valid;
  logic [NSLOT*XW-1:0] obs_x;
  logic [NSLOT*2-1:0]  obs_type;
  logic                spawn_pulse;
  logic                dropped;

  obstacle_spawner #(.NSLOT(NSLOT), .XW(XW), .SCREEN_X(640), .MIN_GAP(MGAP), .GAPB(6)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .frame_tick(frame_tick),
    .speed(speed), .rnd(rnd), .obs_valid(obs_valid), .obs_x(obs_x),
    .obs_type(obs_type), .spawn_pulse(spawn_pulse), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit drop;
    int slot;
    int typ;
  } ev_t;

  ev_t sb_q[$];
  ev_t mon_ev;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_drop   = 0;
  bit  rand_rnd = 1'b0;

  bit  exp_valid [NSLOT];
  int  exp_x     [NSLOT];
  int  exp_type  [NSLOT];
  int  exp_gap;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard monitor: every DUT event must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && (spawn_pulse || dropped)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_event", {spawn_pulse, dropped}, 0);
      end else begin
        mon_ev = sb_q.pop_front();
        check_eq("ev_dropped", dropped, mon_ev.drop);
        check_eq("ev_spawn", spawn_pulse, !mon_ev.drop);
        if (!mon_ev.drop) begin
          check_eq("ev_valid", obs_valid[mon_ev.slot], 1);
          check_eq("ev_x", obs_x[mon_ev.slot*XW +: XW], SX);
          check_eq("ev_type", obs_type[mon_ev.slot*2 +: 2], mon_ev.typ);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NSLOT; i++) exp_valid[i] = 1'b0;
    exp_gap = MGAP;
  endtask

  task automatic model_move();
    for (int i = 0; i < NSLOT; i++) begin
      if (exp_valid[i]) begin
        if (exp_x[i] < int'(speed)) exp_valid[i] = 1'b0;
        else exp_x[i] = exp_x[i] - int'(speed);
      end
    end
  endtask

  task automatic model_spawn(input bit pv [NSLOT]);
    int   found;
    ev_t  e;
    logic [29:0] r;
    r = rnd;
    found = -1;
    for (int i = 0; i < NSLOT; i++) if (!pv[i] && found < 0) found = i;
    if (found >= 0) begin
      exp_valid[found] = 1'b1;
      exp_x[found]     = SX;
      exp_type[found]  = int'(r[1:0]);
      e.drop = 1'b0; e.slot = found; e.typ = int'(r[1:0]);
    end else begin
      e.drop = 1'b1; e.slot = 0; e.typ = 0;
      n_drop++;
    end
    sb_q.push_back(e);
    exp_gap = MGAP + int'(r[7:2]);
  endtask

  task automatic model_step(input bit b2b, input bit clr);
    bit pv [NSLOT];
    if (clr) begin
      model_reset();
    end else if (run) begin
      model_move();
      if (exp_gap == 1) begin
        pv = exp_valid;
        if (b2b) model_move();
        model_spawn(pv);
      end else begin
        exp_gap--;
      end
    end
  endtask

  task automatic compare_slots(input string tag);
    logic [NSLOT-1:0] pv;
    for (int i = 0; i < NSLOT; i++) pv[i] = exp_valid[i];
    check_eq({tag, "_valid"}, obs_valid, pv);
    for (int i = 0; i < NSLOT; i++) begin
      if (exp_valid[i]) begin
        check_eq($sformatf("%s_x%0d", tag, i), obs_x[i*XW +: XW], exp_x[i]);
        check_eq($sformatf("%s_type%0d", tag, i), obs_type[i*2 +: 2], exp_type[i]);
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic frame(input string tag, input bit b2b, input bit clr, input int idle);
    if (rand_rnd) rnd = 30'($urandom);
    frame_tick = 1'b1;
    clear      = clr;
    @(posedge clk); #1;
    model_step(b2b, clr);
    if (b2b) begin
      clear = 1'b0;
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
    clear      = 1'b0;
    repeat (idle) @(posedge clk);
    #1;
    compare_slots(tag);
  endtask

  task automatic frames(input string tag, input int n, input int idle);
    for (int k = 0; k < n; k++) frame(tag, 1'b0, 1'b0, idle);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    compare_slots("clr");
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, obs_valid, 0);
    check_eq({tag, "_x"}, obs_x, 0);
    check_eq({tag, "_type"}, obs_type, 0);
    check_eq({tag, "_spawn"}, spawn_pulse, 0);
    check_eq({tag, "_dropped"}, dropped, 0);
  endtask

  function automatic int n_valid();
    int c = 0;
    for (int i = 0; i < NSLOT; i++) if (exp_valid[i]) c++;
    return c;
  endfunction

  initial begin
    rst_n = 1'b0; run = 1'b0; clear = 1'b0; frame_tick = 1'b0;
    speed = 4'd4; rnd = 30'h9;
    for (int i = 0; i < NSLOT; i++) begin exp_x[i] = 0; exp_type[i] = 0; end
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    run   = 1'b1;
    @(posedge clk); #1;

    // First spawn after 40 ticks, second after 40+2 more (ticks every 10 clk)
    frames("t2a", MGAP, 9);
    check_eq("t2_slot0_x", obs_x[0 +: XW], SX);
    check_eq("t2_slot0_type", obs_type[1:0], 1);
    frames("t2b", 42, 9);
    check_eq("t2_slot0_x2", obs_x[0 +: XW], 471);
    check_eq("t2_slot1_x", obs_x[XW +: XW], SX);

    // Pause: frozen counts and positions, then resume
    frames("t6a", 10, 3);
    run = 1'b0;
    frames("t6p", 50, 3);
    run = 1'b1;
    @(posedge clk); #1;
    frames("t6r", 40, 3);

    // Motion and exit, including x == speed landing on 0
    speed = 4'd9;
    frames("t3", 80, 3);

    // Clear, then back-to-back ticks at gap 1
    speed = 4'd4;
    do_clear();
    frames("t5a", MGAP, 3);
    frames("t5b", 41, 3);
    frame("t5c", 1'b1, 1'b0, 3);
    check_eq("t5_slot0_x", obs_x[0 +: XW], 467);
    check_eq("t5_slot1_x", obs_x[XW +: XW], SX);
    // Clear together with the expiring tick: no spawn, everything dropped
    frames("t5d", 41, 3);
    frame("t5e", 1'b0, 1'b1, 3);
    frames("t5f", MGAP, 3);

    // All slots busy with no motion: spawn due -> dropped
    speed    = 4'd0;
    rand_rnd = 1'b1;
    for (int k = 0; k < 800 && n_drop < 2; k++) frame("t4", 1'b0, 1'b0, 3);
    frames("t4b", 5, 3);

    // Asynchronous reset mid-run with three live slots
    do_clear();
    for (int k = 0; k < 600 && n_valid() < 3; k++) frame("t1a", 1'b0, 1'b0, 3);
    check_eq("t1_pre_valid", obs_valid, 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    check_zero("t1_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    speed = 4'd3;
    frames("t1b", MGAP + 5, 3);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
